// File: rtl/mac_sequencer.sv
// Sequencer for a neuron dot-product engine: streams pixel/weight reads, steers the MAC core
// and hands out one result per neuron. Define MAC_SEQ_RELU_EN to clamp negative results to zero.
`timescale 1ns/1ps

module mac_sequencer #(
    parameter int BITS    = 24,
    parameter int WIDTH   = 784,
    parameter int NEURONS = 10,
    parameter int MEM_LAT = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               rd_en,
    output logic [$clog2(WIDTH)-1:0]           pix_addr,
    output logic [$clog2(NEURONS*WIDTH)-1:0]   w_addr,
    output logic                               mac_clr,
    output logic                               mac_en,
    input  logic [BITS-1:0]                    mac_acc,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [BITS-1:0]                    res_data,
    output logic [$clog2(NEURONS)-1:0]         res_idx,
    output logic                               done
);

    localparam int PW = $clog2(WIDTH);
    localparam int NW = $clog2(NEURONS*WIDTH);
    localparam int IW = $clog2(NEURONS);
    localparam int DW = $clog2(MEM_LAT+1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] OUTPUT = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]         state;
    logic [IW-1:0]      neuron;
    logic [DW-1:0]      drain_cnt;
    logic [MEM_LAT-1:0] rd_dly;
    logic [BITS-1:0]    captured;

`ifdef MAC_SEQ_RELU_EN
    assign captured = mac_acc[BITS-1] ? '0 : mac_acc;
`else
    assign captured = mac_acc;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            neuron    <= '0;
            pix_addr  <= '0;
            drain_cnt <= '0;
            res_data  <= '0;
            res_idx   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    neuron <= '0;
                    state  <= CLEAR;
                end
                CLEAR: begin
                    pix_addr <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    // Address saturates on the last pixel rather than wrapping.
                    if (pix_addr == PW'(WIDTH-1)) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        pix_addr <= pix_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(MEM_LAT)) begin
                        res_data <= captured;
                        res_idx  <= neuron;
                        state    <= OUTPUT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                OUTPUT: if (res_ready) begin
                    if (neuron == IW'(NEURONS-1)) begin
                        state <= DONE;
                    end else begin
                        neuron <= neuron + 1'b1;
                        state  <= CLEAR;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the read-to-accumulate delay line is reset (and cleared per neuron) so no stale strobe leaks into a fresh sum.
    always_ff @(posedge clk) begin
        if (reset || state == CLEAR) begin
            rd_dly <= '0;
        end else begin
            rd_dly[0] <= rd_en;
            for (int i = 1; i < MEM_LAT; i++) rd_dly[i] <= rd_dly[i-1];
        end
    end

    assign busy      = (state != IDLE);
    assign rd_en     = (state == STREAM);
    assign mac_clr   = (state == CLEAR);
    assign mac_en    = rd_dly[MEM_LAT-1];
    assign res_valid = (state == OUTPUT);
    assign done      = (state == DONE);
    assign w_addr    = NW'(neuron) * NW'(WIDTH) + NW'(pix_addr);

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: a behavioural memory + MAC model feeds the DUT and
// results are compared to dot products computed directly from the memory contents.
`timescale 1ns/1ps

module tb_mac_sequencer;

    localparam int BITS    = 24;
    localparam int WIDTH   = 4;
    localparam int NEURONS = 2;
    localparam int MEM_LAT = 1;
    localparam int STEP    = WIDTH + MEM_LAT + 3;

    logic                               clk = 1'b0;
    logic                               reset;
    logic                               start;
    logic                               busy, rd_en, mac_clr, mac_en, res_valid, done;
    logic [$clog2(WIDTH)-1:0]           pix_addr;
    logic [$clog2(NEURONS*WIDTH)-1:0]   w_addr;
    logic [BITS-1:0]                    mac_acc;
    logic                               res_ready;
    logic [BITS-1:0]                    res_data;
    logic [$clog2(NEURONS)-1:0]         res_idx;

    mac_sequencer #(.BITS(BITS), .WIDTH(WIDTH), .NEURONS(NEURONS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .rd_en(rd_en),
        .pix_addr(pix_addr), .w_addr(w_addr), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx), .done(done)
    );

    always #5 clk = ~clk;

    // Pixel buffer / weight ROM with one cycle of read latency, followed by an accumulator.
    logic [BITS-1:0] pix_mem [WIDTH];
    logic [BITS-1:0] w_mem   [NEURONS*WIDTH];
    logic [BITS-1:0] prod_q, acc;

    always @(posedge clk) begin
        if (rd_en) prod_q <= pix_mem[pix_addr] * w_mem[w_addr];
        if (reset || mac_clr) acc <= '0;
        else if (mac_en)      acc <= acc + prod_q;
    end
    assign mac_acc = acc;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of one image run.
    int              res_first_cyc[$], res_acc_cyc[$], res_i[$];
    logic [BITS-1:0] res_d[$];
    int              rd_cyc[$], rd_pix[$], rd_w[$], en_cyc[$], done_cyc[$];
    bit              unstable, rd_in_output, timeout;
    logic            busy_c1, busy_after;
    logic [5:0]      idle_bits;

    function automatic logic [BITS-1:0] ref_dot(input int n);
        logic [BITS-1:0] s;
        s = '0;
        for (int p = 0; p < WIDTH; p++) s = s + pix_mem[p] * w_mem[n*WIDTH + p];
`ifdef MAC_SEQ_RELU_EN
        if (s[BITS-1]) s = '0;
`endif
        return s;
    endfunction

    task automatic load_basic();
        for (int p = 0; p < WIDTH; p++) begin
            pix_mem[p]       = BITS'(10 * (p + 1));
            w_mem[p]         = BITS'(1);
            w_mem[WIDTH + p] = BITS'(2);
        end
    endtask

    task automatic load_random();
        for (int p = 0; p < WIDTH; p++) pix_mem[p] = BITS'($urandom);
        for (int k = 0; k < NEURONS*WIDTH; k++) w_mem[k] = BITS'($urandom);
    endtask

    // Starts one image (start sampled in cycle 0) and records what the DUT does until two cycles after done.
    task automatic run_image(input int stall, input int repulse_a, input int repulse_b);
        int cyc, wcnt, stop_at;
        bit in_out, hs_pending;
        logic [BITS-1:0] hd;
        int hi;
        res_first_cyc.delete(); res_acc_cyc.delete(); res_i.delete(); res_d.delete();
        rd_cyc.delete(); rd_pix.delete(); rd_w.delete(); en_cyc.delete(); done_cyc.delete();
        unstable = 0; rd_in_output = 0; timeout = 0; busy_c1 = 1'bx; busy_after = 1'bx; idle_bits = 'x;
        @(negedge clk);
        start = 1'b1;
        res_ready = (stall == 0);
        @(posedge clk);
        cyc = 0; wcnt = 0; stop_at = -1; in_out = 0; hs_pending = 0; hd = '0; hi = 0;
        forever begin
            @(negedge clk);
            cyc++;
            start = (cyc == repulse_a || cyc == repulse_b);
            if (hs_pending) begin res_ready = (stall == 0); hs_pending = 0; end
            if (cyc == 1) busy_c1 = busy;
            if (rd_en) begin rd_cyc.push_back(cyc); rd_pix.push_back(int'(pix_addr)); rd_w.push_back(int'(w_addr)); end
            if (mac_en) en_cyc.push_back(cyc);
            if (done) begin
                done_cyc.push_back(cyc);
                if (stop_at < 0) stop_at = cyc + 2;
            end
            if (res_valid) begin
                if (!in_out) begin
                    in_out = 1; wcnt = 0; hd = res_data; hi = int'(res_idx);
                    res_first_cyc.push_back(cyc);
                end else if (res_data !== hd || int'(res_idx) != hi) begin
                    unstable = 1;
                end
                if (rd_en) rd_in_output = 1;
                if (wcnt >= stall) res_ready = 1'b1;
                if (res_ready) begin
                    res_acc_cyc.push_back(cyc); res_d.push_back(res_data); res_i.push_back(int'(res_idx));
                    in_out = 0; hs_pending = 1;
                end else begin
                    wcnt++;
                end
            end
            if (stop_at > 0 && cyc == stop_at - 1) busy_after = busy;
            if (cyc == stop_at) begin
                idle_bits = {busy, rd_en, mac_clr, mac_en, res_valid, done};
                break;
            end
            if (cyc > 400) begin timeout = 1; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            n_tests++; if ({busy, rd_en, mac_clr, mac_en, res_valid, done} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl ph%0d got=%b want=000000", ph, {busy, rd_en, mac_clr, mac_en, res_valid, done}); end
            n_tests++; if (pix_addr !== '0) begin n_fail++; $display("FAIL reset_pix ph%0d got=%0d want=0", ph, pix_addr); end
            n_tests++; if (w_addr !== '0) begin n_fail++; $display("FAIL reset_w ph%0d got=%0d want=0", ph, w_addr); end
            n_tests++; if (res_data !== '0) begin n_fail++; $display("FAIL reset_data ph%0d got=%h want=0", ph, res_data); end
            n_tests++; if (res_idx !== '0) begin n_fail++; $display("FAIL reset_idx ph%0d got=%0d want=0", ph, res_idx); end
            reset = 1'b0;
        end
    endtask

    task automatic test_basic();
        load_basic();
        run_image(0, -1, -1);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL basic_timeout got=no_done want=done"); end
        n_tests++; if (res_d.size() != NEURONS) begin n_fail++; $display("FAIL basic_count got=%0d want=%0d", res_d.size(), NEURONS); end
        for (int k = 0; k < res_d.size() && k < NEURONS; k++) begin
            n_tests++; if (res_first_cyc[k] != STEP * (k + 1)) begin n_fail++; $display("FAIL basic_valid_cyc%0d got=%0d want=%0d", k, res_first_cyc[k], STEP*(k+1)); end
            n_tests++; if (res_acc_cyc[k] != res_first_cyc[k]) begin n_fail++; $display("FAIL basic_hs_cyc%0d got=%0d want=%0d", k, res_acc_cyc[k], res_first_cyc[k]); end
            n_tests++; if (res_d[k] !== BITS'(100 * (k + 1))) begin n_fail++; $display("FAIL basic_data%0d got=%0d want=%0d", k, res_d[k], 100*(k+1)); end
            n_tests++; if (res_i[k] != k) begin n_fail++; $display("FAIL basic_idx%0d got=%0d want=%0d", k, res_i[k], k); end
        end
        n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 2*STEP + 1) begin n_fail++; $display("FAIL basic_done got=%0d pulses first=%0d want=1 pulse at %0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, 2*STEP+1); end
        n_tests++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_c1 got=%b want=1", busy_c1); end
        n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b want=0", busy_after); end
        n_tests++; if (idle_bits !== 6'b0) begin n_fail++; $display("FAIL basic_idle_outputs got=%b want=000000", idle_bits); end
    endtask

    // Uses the trace recorded by the immediately preceding test_basic run.
    task automatic test_trace();
        n_tests++; if (rd_cyc.size() != NEURONS*WIDTH) begin n_fail++; $display("FAIL trace_rd_count got=%0d want=%0d", rd_cyc.size(), NEURONS*WIDTH); end
        n_tests++; if (en_cyc.size() != NEURONS*WIDTH) begin n_fail++; $display("FAIL trace_en_count got=%0d want=%0d", en_cyc.size(), NEURONS*WIDTH); end
        for (int k = 0; k < rd_cyc.size() && k < en_cyc.size() && k < NEURONS*WIDTH; k++) begin
            n_tests++; if (rd_pix[k] != k % WIDTH) begin n_fail++; $display("FAIL trace_pix%0d got=%0d want=%0d", k, rd_pix[k], k % WIDTH); end
            n_tests++; if (rd_w[k] != k) begin n_fail++; $display("FAIL trace_w%0d got=%0d want=%0d", k, rd_w[k], k); end
            n_tests++; if (rd_cyc[k] != 2 + (k / WIDTH) * STEP + (k % WIDTH)) begin n_fail++; $display("FAIL trace_rd_cyc%0d got=%0d want=%0d", k, rd_cyc[k], 2 + (k/WIDTH)*STEP + (k%WIDTH)); end
            n_tests++; if (en_cyc[k] != rd_cyc[k] + MEM_LAT) begin n_fail++; $display("FAIL trace_en_cyc%0d got=%0d want=%0d", k, en_cyc[k], rd_cyc[k] + MEM_LAT); end
        end
    endtask

    task automatic test_backpressure();
        load_random();
        run_image(5, -1, -1);
        n_tests++; if (timeout || res_d.size() != NEURONS) begin n_fail++; $display("FAIL bp_count got=%0d timeout=%0d want=%0d", res_d.size(), timeout, NEURONS); end
        n_tests++; if (unstable) begin n_fail++; $display("FAIL bp_stable got=changed want=held"); end
        n_tests++; if (rd_in_output) begin n_fail++; $display("FAIL bp_rd_in_output got=1 want=0"); end
        n_tests++; if (rd_cyc.size() != NEURONS*WIDTH) begin n_fail++; $display("FAIL bp_rd_count got=%0d want=%0d", rd_cyc.size(), NEURONS*WIDTH); end
        for (int k = 0; k < res_d.size() && k < NEURONS; k++) begin
            n_tests++; if (res_d[k] !== ref_dot(k)) begin n_fail++; $display("FAIL bp_data%0d got=%h want=%h", k, res_d[k], ref_dot(k)); end
            n_tests++; if (res_i[k] != k) begin n_fail++; $display("FAIL bp_idx%0d got=%0d want=%0d", k, res_i[k], k); end
            n_tests++; if (res_acc_cyc[k] != res_first_cyc[k] + 5) begin n_fail++; $display("FAIL bp_hold%0d got=%0d want=%0d", k, res_acc_cyc[k], res_first_cyc[k] + 5); end
            n_tests++; if (res_first_cyc[k] != ((k == 0) ? STEP : res_acc_cyc[k-1] + STEP)) begin n_fail++; $display("FAIL bp_valid_cyc%0d got=%0d", k, res_first_cyc[k]); end
        end
        n_tests++; if (done_cyc.size() != 1 || res_acc_cyc.size() != NEURONS || done_cyc[0] != res_acc_cyc[NEURONS-1] + 1) begin n_fail++; $display("FAIL bp_done got=%0d pulses want=1 after last handshake", done_cyc.size()); end
    endtask

    task automatic test_reset_mid_stream();
        bit found;
        load_basic();
        @(negedge clk);
        start = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rd_en && pix_addr == 2) found = 1;
            else @(negedge clk);
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL midrst_reach got=no_pix2 want=pix2"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if ({busy, rd_en, mac_clr, mac_en, res_valid, done} !== 6'b0) begin n_fail++; $display("FAIL midrst_ctrl got=%b want=000000", {busy, rd_en, mac_clr, mac_en, res_valid, done}); end
        n_tests++; if (pix_addr !== '0 || w_addr !== '0) begin n_fail++; $display("FAIL midrst_addr got=%0d/%0d want=0/0", pix_addr, w_addr); end
        n_tests++; if (res_data !== '0 || res_idx !== '0) begin n_fail++; $display("FAIL midrst_res got=%h/%0d want=0/0", res_data, res_idx); end
        run_image(0, -1, -1);
        n_tests++; if (timeout || res_d.size() != NEURONS) begin n_fail++; $display("FAIL midrst_count got=%0d want=%0d", res_d.size(), NEURONS); end
        for (int k = 0; k < res_d.size() && k < NEURONS; k++) begin
            n_tests++; if (res_first_cyc[k] != STEP * (k + 1) || res_d[k] !== BITS'(100 * (k + 1)) || res_i[k] != k) begin n_fail++; $display("FAIL midrst_res%0d got=cyc%0d data%0d idx%0d want=cyc%0d data%0d idx%0d", k, res_first_cyc[k], res_d[k], res_i[k], STEP*(k+1), 100*(k+1), k); end
        end
        n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 2*STEP + 1) begin n_fail++; $display("FAIL midrst_done got=%0d pulses want=1 at %0d", done_cyc.size(), 2*STEP+1); end
    endtask

    task automatic test_start_ignored();
        load_random();
        run_image(0, 4, 2*STEP + 1);
        n_tests++; if (timeout || res_d.size() != NEURONS) begin n_fail++; $display("FAIL restart_count got=%0d want=%0d", res_d.size(), NEURONS); end
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL restart_done got=%0d want=1", done_cyc.size()); end
        n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL restart_busy_after got=%b want=0", busy_after); end
        for (int k = 0; k < res_d.size() && k < NEURONS; k++) begin
            n_tests++; if (res_d[k] !== ref_dot(k) || res_first_cyc[k] != STEP * (k + 1)) begin n_fail++; $display("FAIL restart_res%0d got=%h@%0d want=%h@%0d", k, res_d[k], res_first_cyc[k], ref_dot(k), STEP*(k+1)); end
        end
    endtask

    task automatic test_relu();
        logic [BITS-1:0] want;
        for (int p = 0; p < WIDTH; p++) begin
            pix_mem[p] = '0; w_mem[p] = '0; w_mem[WIDTH + p] = BITS'($urandom_range(0, 9));
        end
        pix_mem[0] = BITS'(1);
        w_mem[0]   = BITS'(-5);
`ifdef MAC_SEQ_RELU_EN
        want = '0;
`else
        want = 24'hFFFFFB;
`endif
        run_image(0, -1, -1);
        n_tests++; if (res_d.size() < 1 || res_d[0] !== want) begin n_fail++; $display("FAIL relu_neg got=%h want=%h", (res_d.size() > 0) ? res_d[0] : '0, want); end
        n_tests++; if (res_d.size() < 2 || res_d[1] !== ref_dot(1)) begin n_fail++; $display("FAIL relu_pos got=%0d results want=%h", res_d.size(), ref_dot(1)); end
    endtask

    task automatic test_random();
        int stall;
        for (int it = 0; it < 6; it++) begin
            load_random();
            stall = $urandom_range(0, 3);
            run_image(stall, -1, -1);
            n_tests++; if (timeout || res_d.size() != NEURONS || done_cyc.size() != 1) begin n_fail++; $display("FAIL rand%0d_count got=%0d res %0d done want=%0d/1", it, res_d.size(), done_cyc.size(), NEURONS); end
            for (int k = 0; k < res_d.size() && k < NEURONS; k++) begin
                n_tests++; if (res_d[k] !== ref_dot(k) || res_i[k] != k) begin n_fail++; $display("FAIL rand%0d_res%0d got=%h/%0d want=%h/%0d", it, k, res_d[k], res_i[k], ref_dot(k), k); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trace();
        test_backpressure();
        test_reset_mid_stream();
        test_start_ignored();
        test_relu();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
